// File: rtl/pwm_multi_core.sv
// N-channel PWM core: shared edge/center-aligned timebase, per-channel duty compare,
// shadow configuration applied at period boundaries. Optional macro: PWM_MULTI_POLARITY_EN.
module pwm_multi_core #(
    parameter int NUM_CH                = 4,
    parameter int CNT_WIDTH             = 16,
    parameter int DEFAULT_PERIOD_CYCLES = 5000,
    parameter int DEFAULT_DUTY_CYCLES   = 2500
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          cfg_wr_i,
    input  logic                          center_align_i,
    input  logic [CNT_WIDTH-1:0]          period_cycles_i,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   duty_cycles_i,
    input  logic [NUM_CH-1:0]             use_default_duty_i,
`ifdef PWM_MULTI_POLARITY_EN
    input  logic [NUM_CH-1:0]             pol_i,
`endif
    output logic [CNT_WIDTH-1:0]          cnt,
    output logic                          period_start,
    output logic                          period_end,
    output logic                          cfg_pending,
    output logic [NUM_CH-1:0]             pwm_raw
);

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

    localparam logic [CNT_WIDTH-1:0] DEF_PERIOD = CNT_WIDTH'(DEFAULT_PERIOD_CYCLES);
    localparam logic [CNT_WIDTH-1:0] DEF_DUTY   = CNT_WIDTH'(DEFAULT_DUTY_CYCLES);
    localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TWO        = CNT_WIDTH'(2);

    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    dir_t                 dir_reg, dir_next;
    logic                 cfg_pending_reg;

    logic                 stg_center_reg, act_center_reg;
    logic [CNT_WIDTH-1:0] stg_period_reg, act_period_reg;
    logic [CNT_WIDTH-1:0] stg_duty_reg [NUM_CH];
    logic [CNT_WIDTH-1:0] act_duty_reg [NUM_CH];
    logic [NUM_CH-1:0]    stg_use_def_reg, act_use_def_reg;
    logic [NUM_CH-1:0]    act_pol;

    logic [CNT_WIDTH-1:0] per_eff, per_last;
    logic                 end_int, apply;

    assign per_eff  = (act_period_reg == '0) ? DEF_PERIOD : act_period_reg;
    assign per_last = per_eff - ONE;

    // Center mode ends a period on the down-count 1; tiny periods never count down.
    always_comb begin
        end_int = 1'b0;
        if (enable) begin
            if (act_center_reg)
                end_int = ((per_eff <= TWO) && (cnt_reg == per_last)) ||
                          ((dir_reg == DIR_DOWN) && (cnt_reg == ONE));
            else
                end_int = (cnt_reg == per_last);
        end
    end

    // While idle the active set tracks staging continuously.
    assign apply = enable ? (end_int && cfg_pending_reg) : 1'b1;

    always_comb begin
        cnt_next = cnt_reg;
        dir_next = dir_reg;
        if (!enable || end_int) begin
            cnt_next = '0;
            dir_next = DIR_UP;
        end else if (!act_center_reg) begin
            cnt_next = cnt_reg + ONE;
        end else if (dir_reg == DIR_UP) begin
            if (cnt_reg == per_last) begin
                cnt_next = cnt_reg - ONE;
                dir_next = DIR_DOWN;
            end else begin
                cnt_next = cnt_reg + ONE;
            end
        end else begin
            cnt_next = cnt_reg - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg         <= '0;
            dir_reg         <= DIR_UP;
            cfg_pending_reg <= 1'b0;
            stg_center_reg  <= 1'b0;
            act_center_reg  <= 1'b0;
            stg_period_reg  <= '0;
            act_period_reg  <= '0;
            stg_use_def_reg <= '0;
            act_use_def_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
            dir_reg <= dir_next;
            if (cfg_wr_i) begin
                stg_center_reg  <= center_align_i;
                stg_period_reg  <= period_cycles_i;
                stg_use_def_reg <= use_default_duty_i;
            end
            if (apply) begin
                act_center_reg  <= stg_center_reg;
                act_period_reg  <= stg_period_reg;
                act_use_def_reg <= stg_use_def_reg;
            end
            if (cfg_wr_i)
                cfg_pending_reg <= 1'b1;
            else if (apply)
                cfg_pending_reg <= 1'b0;
        end
    end

`ifdef PWM_MULTI_POLARITY_EN
    logic [NUM_CH-1:0] stg_pol_reg, act_pol_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_pol_reg <= '0;
            act_pol_reg <= '0;
        end else begin
            if (cfg_wr_i)
                stg_pol_reg <= pol_i;
            if (apply)
                act_pol_reg <= stg_pol_reg;
        end
    end

    assign act_pol = act_pol_reg;
`else
    assign act_pol = '0;
`endif

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_WIDTH-1:0] duty_eff;

            always_ff @(posedge clk) begin
                if (rst) begin
                    stg_duty_reg[gi] <= '0;
                    act_duty_reg[gi] <= '0;
                end else begin
                    if (cfg_wr_i)
                        stg_duty_reg[gi] <= duty_cycles_i[gi*CNT_WIDTH +: CNT_WIDTH];
                    if (apply)
                        act_duty_reg[gi] <= stg_duty_reg[gi];
                end
            end

            assign duty_eff    = act_use_def_reg[gi] ? DEF_DUTY : act_duty_reg[gi];
            assign pwm_raw[gi] = act_pol[gi] ^ (enable && (cnt_reg < duty_eff));
        end
    endgenerate

    assign cnt          = cnt_reg;
    assign period_start = enable && (cnt_reg == '0);
    assign period_end   = end_int;
    assign cfg_pending  = cfg_pending_reg;

endmodule
